noise_est_seq_ctrl: RTL and testbench

Sequencer that sits between an upstream pixel stream (valid/ready) and the noise_estimation datapath. It buffers each block of TOTAL_SAMPLES pixels so every block reaches the estimator as one contiguous burst. It generates start_data, start_of_frame and end_of_frame, and paces blocks on mean_ready. At the end of each frame it captures estimated_noise and reports it with a one-cycle valid pulse. A watchdog sets a sticky error if the estimator stops responding.

---
 rtl/noise_est_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/noise_est_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_noise_est_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_est_pkg.sv
// Shared definitions for the noise-estimation sequencer.
// Contents:
//   ctrl_state_t        controller FSM states
//   DEF_DATA_WIDTH      default pixel width
//   DEF_TOTAL_SAMPLES   default pixels per block
package noise_est_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_TOTAL_SAMPLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLOCK,
    START,
    STREAM,
    WAIT_MEAN,
    GAP,
    WAIT_NOISE
  } ctrl_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO buffering upstream pixels ahead of the estimator.
// The head entry is presented combinationally so a pop and its data
// appear in the same cycle, which keeps bursts free of bubbles.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push         write push_data (ignored while full)
//   push_data    incoming word
//   pop          drop the head entry (ignored while empty)
//   head_data    current head entry
//   flush        discard all contents
//   count        number of stored entries (0..FIFO_DEPTH)
//   full         count == FIFO_DEPTH
module sync_fifo
  import noise_est_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head_data,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [AW:0]           count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign count     = count_reg;
  assign do_push   = push && !full;
  assign do_pop    = pop && (count_reg != '0);
  assign head_data = mem[rd_ptr_reg];

  // Storage carries no reset; stale words are never read past count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/noise_est_seq_ctrl.sv
// Sequencer between an upstream valid/ready pixel stream and the
// noise-estimation datapath. Whole blocks of TOTAL_SAMPLES pixels are
// buffered and then sent as one contiguous burst, framed by start_data,
// start_of_frame and end_of_frame. Blocks are paced on the estimator's
// mean_ready; the final estimate of each frame is captured and reported
// with a one-cycle pulse. A watchdog aborts the frame if the estimator
// goes silent.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   en                         permit a new frame (looked at in IDLE only)
//   blocks_per_frame           blocks per frame, latched at frame start (0 -> 1)
//   pix_valid/pix_data/pix_ready  upstream pixel handshake
//   ne_start_of_frame, ne_end_of_frame, ne_start_data, ne_data,
//   ne_blocks_per_frame        drive the estimator
//   ne_mean_ready, ne_estimated_noise, ne_estimated_noise_ready
//                              estimator responses
//   noise_out, noise_valid     captured estimate and its update pulse
//   frame_count                completed frames (wraps)
//   busy                       controller not idle
//   err_timeout                sticky watchdog flag
module noise_est_seq_ctrl
  import noise_est_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TOTAL_SAMPLES  = DEF_TOTAL_SAMPLES,
  parameter int FIFO_DEPTH     = 32,
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [31:0]             blocks_per_frame,
  input  logic                    pix_valid,
  input  logic [DATA_WIDTH-1:0]   pix_data,
  output logic                    pix_ready,
  output logic                    ne_start_of_frame,
  output logic                    ne_end_of_frame,
  output logic                    ne_start_data,
  output logic [DATA_WIDTH-1:0]   ne_data,
  output logic [31:0]             ne_blocks_per_frame,
  input  logic                    ne_mean_ready,
  input  logic [2*DATA_WIDTH-1:0] ne_estimated_noise,
  input  logic                    ne_estimated_noise_ready,
  output logic [2*DATA_WIDTH-1:0] noise_out,
  output logic                    noise_valid,
  output logic [15:0]             frame_count,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (TOTAL_SAMPLES > 1) ? $clog2(TOTAL_SAMPLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  ctrl_state_t             state_reg, state_next;
  logic [31:0]             bpf_reg, bpf_next;
  logic [31:0]             blk_idx_reg, blk_idx_next;
  logic [BW-1:0]           beat_reg, beat_next;
  logic [GW-1:0]           gap_reg, gap_next;
  logic [WW-1:0]           wd_reg, wd_next;
  logic                    mean_prev_reg;
  logic                    mean_seen_reg, mean_seen_next;
  logic [DATA_WIDTH-1:0]   data_hold_reg;
  logic [2*DATA_WIDTH-1:0] noise_out_reg;
  logic                    noise_valid_reg;
  logic [15:0]             frame_count_reg;
  logic                    err_reg;

  logic                    mean_rise;
  logic                    last_blk;
  logic                    fifo_pop;
  logic                    fifo_flush;
  logic                    fifo_full;
  logic [CW-1:0]           fifo_count;
  logic [DATA_WIDTH-1:0]   fifo_head;
  logic                    capture_noise;
  logic                    set_err;
  logic                    start_c, sof_c, eof_c;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pix_valid),
    .push_data (pix_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // Edge detect so a mean_ready level left over from the previous block
  // is not mistaken for a fresh response.
  assign mean_rise = ne_mean_ready && !mean_prev_reg;
  assign last_blk  = (blk_idx_reg == bpf_reg - 32'd1);

  always_comb begin
    state_next     = state_reg;
    bpf_next       = bpf_reg;
    blk_idx_next   = blk_idx_reg;
    beat_next      = beat_reg;
    gap_next       = gap_reg;
    wd_next        = wd_reg;
    mean_seen_next = mean_seen_reg;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    capture_noise  = 1'b0;
    set_err        = 1'b0;
    start_c        = 1'b0;
    sof_c          = 1'b0;
    eof_c          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en) begin
          bpf_next     = (blocks_per_frame == 32'd0) ? 32'd1 : blocks_per_frame;
          blk_idx_next = '0;
          state_next   = WAIT_BLOCK;
        end
      end

      WAIT_BLOCK: begin
        if (fifo_count >= CW'(TOTAL_SAMPLES)) begin
          state_next = START;
        end
      end

      START: begin
        start_c        = 1'b1;
        sof_c          = (blk_idx_reg == 32'd0);
        eof_c          = last_blk;
        // Forget any earlier response but keep one arriving right now.
        mean_seen_next = mean_rise;
        beat_next      = '0;
        state_next     = STREAM;
      end

      STREAM: begin
        fifo_pop = 1'b1;
        if (mean_rise) begin
          mean_seen_next = 1'b1;
        end
        if (beat_reg == BW'(TOTAL_SAMPLES - 1)) begin
          wd_next = '0;
          if (last_blk) begin
            state_next = WAIT_NOISE;
          end else begin
            blk_idx_next = blk_idx_reg + 32'd1;
            state_next   = WAIT_MEAN;
          end
        end else begin
          beat_next = beat_reg + BW'(1);
        end
      end

      WAIT_MEAN: begin
        if (mean_rise) begin
          mean_seen_next = 1'b1;
        end
        if (mean_seen_reg) begin
          gap_next = '0;
          if (GAP_CYCLES == 0) begin
            state_next = WAIT_BLOCK;
          end else begin
            state_next = GAP;
          end
        end else if (wd_reg == WW'(TIMEOUT_CYCLES - 1)) begin
          set_err    = 1'b1;
          fifo_flush = 1'b1;
          state_next = IDLE;
        end else begin
          wd_next = wd_reg + WW'(1);
        end
      end

      GAP: begin
        if (gap_reg == GW'(GAP_CYCLES - 1)) begin
          state_next = WAIT_BLOCK;
        end else begin
          gap_next = gap_reg + GW'(1);
        end
      end

      WAIT_NOISE: begin
        if (ne_estimated_noise_ready) begin
          capture_noise = 1'b1;
          state_next    = IDLE;
        end else if (wd_reg == WW'(TIMEOUT_CYCLES - 1)) begin
          set_err    = 1'b1;
          fifo_flush = 1'b1;
          state_next = IDLE;
        end else begin
          wd_next = wd_reg + WW'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      bpf_reg         <= 32'd1;
      blk_idx_reg     <= '0;
      beat_reg        <= '0;
      gap_reg         <= '0;
      wd_reg          <= '0;
      mean_prev_reg   <= 1'b0;
      mean_seen_reg   <= 1'b0;
      data_hold_reg   <= '0;
      noise_out_reg   <= '0;
      noise_valid_reg <= 1'b0;
      frame_count_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bpf_reg         <= bpf_next;
      blk_idx_reg     <= blk_idx_next;
      beat_reg        <= beat_next;
      gap_reg         <= gap_next;
      wd_reg          <= wd_next;
      mean_prev_reg   <= ne_mean_ready;
      mean_seen_reg   <= mean_seen_next;
      noise_valid_reg <= capture_noise;
      if (fifo_pop) begin
        data_hold_reg <= fifo_head;
      end
      if (capture_noise) begin
        noise_out_reg   <= ne_estimated_noise;
        frame_count_reg <= frame_count_reg + 16'd1;
      end
      if (set_err) begin
        err_reg <= 1'b1;
      end
    end
  end

  // During STREAM the head word goes straight out so each pop lands in the
  // same cycle; otherwise the last streamed word is held.
  assign ne_data             = (state_reg == STREAM) ? fifo_head : data_hold_reg;
  assign ne_start_data       = start_c;
  assign ne_start_of_frame   = sof_c;
  assign ne_end_of_frame     = eof_c;
  assign ne_blocks_per_frame = bpf_reg;
  assign pix_ready           = !fifo_full;
  assign noise_out           = noise_out_reg;
  assign noise_valid         = noise_valid_reg;
  assign frame_count         = frame_count_reg;
  assign busy                = (state_reg != IDLE);
  assign err_timeout         = err_reg;

endmodule

// File: tb/tb_noise_est_seq_ctrl.sv
// Directed bench for noise_est_seq_ctrl with a small estimator model and a
// pixel scoreboard.
module tb_noise_est_seq_ctrl;

  localparam int DW  = 8;
  localparam int TS  = 16;
  localparam int GAP = 3;
  localparam int TO  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [31:0]   blocks_per_frame = '0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          pix_ready;
  logic          ne_start_of_frame, ne_end_of_frame, ne_start_data;
  logic [DW-1:0] ne_data;
  logic [31:0]   ne_blocks_per_frame;
  logic          ne_mean_ready = 1'b0;
  logic [2*DW-1:0] ne_estimated_noise = '0;
  logic          ne_estimated_noise_ready = 1'b0;
  logic [2*DW-1:0] noise_out;
  logic          noise_valid;
  logic [15:0]   frame_count;
  logic          busy, err_timeout;

  noise_est_seq_ctrl #(
    .DATA_WIDTH(DW), .TOTAL_SAMPLES(TS), .FIFO_DEPTH(32),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .blocks_per_frame(blocks_per_frame),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .ne_start_of_frame(ne_start_of_frame), .ne_end_of_frame(ne_end_of_frame),
    .ne_start_data(ne_start_data), .ne_data(ne_data),
    .ne_blocks_per_frame(ne_blocks_per_frame), .ne_mean_ready(ne_mean_ready),
    .ne_estimated_noise(ne_estimated_noise),
    .ne_estimated_noise_ready(ne_estimated_noise_ready),
    .noise_out(noise_out), .noise_valid(noise_valid), .frame_count(frame_count),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix_val(input int i);
    return DW'(184 + 148 * i);
  endfunction

  // Scoreboard and estimator-model state
  logic [DW-1:0] exp_q[$];
  int  pix_idx = 0;
  bit  mean_en = 1'b1;
  logic [2*DW-1:0] noise_val = 16'h1234;
  int  n_start, n_sof, n_eof, n_nv, beats_left, beat_no;
  int  mean_cd, noise_cd, mean_rise_cyc, err_cyc, last_beat_cyc;
  bit  mean_pending, burst_last;
  bit  sof_hist[16];
  bit  eof_hist[16];
  logic [DW-1:0] first_beats[2];

  always @(negedge clk) begin
    if (!rst_n) begin
      n_start = 0; n_sof = 0; n_eof = 0; n_nv = 0; beats_left = 0; beat_no = 0;
      mean_cd = 0; noise_cd = 0; mean_rise_cyc = 0; err_cyc = 0; last_beat_cyc = 0;
      mean_pending = 0; burst_last = 0;
      for (int i = 0; i < 16; i++) begin sof_hist[i] = 0; eof_hist[i] = 0; end
      ne_mean_ready = 1'b0;
      ne_estimated_noise_ready = 1'b0;
    end else begin
      ne_mean_ready = 1'b0;
      ne_estimated_noise_ready = 1'b0;
      if (mean_cd > 0) begin
        mean_cd--;
        if (mean_cd == 0) begin
          ne_mean_ready = 1'b1;
          mean_rise_cyc = cyc;
          mean_pending  = 1'b1;
        end
      end
      if (noise_cd > 0) begin
        noise_cd--;
        if (noise_cd == 0) begin
          ne_estimated_noise = noise_val;
          ne_estimated_noise_ready = 1'b1;
        end
      end
      if (noise_valid) begin
        n_nv++;
        $display("frame done: noise_out=0x%04h frame_count=%0d", noise_out, frame_count);
      end
      if (err_timeout && err_cyc == 0) err_cyc = cyc;
      if (ne_start_data) begin
        if (n_start < 16) begin
          sof_hist[n_start] = ne_start_of_frame;
          eof_hist[n_start] = ne_end_of_frame;
        end
        n_start++;
        if (ne_start_of_frame) n_sof++;
        if (ne_end_of_frame) n_eof++;
        if (mean_pending) begin
          check("gap_spacing", 32'((cyc - mean_rise_cyc) > GAP), 32'd1);
          mean_pending = 1'b0;
        end
        $display("burst %0d start: sof=%0b eof=%0b", n_start, ne_start_of_frame, ne_end_of_frame);
        beats_left = TS;
        beat_no    = 0;
        burst_last = ne_end_of_frame;
      end else if (beats_left > 0) begin
        logic [DW-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("beat", 32'(ne_data), 32'(e));
        if (n_start == 1 && beat_no < 2) first_beats[beat_no] = ne_data;
        beat_no++;
        beats_left--;
        if (beats_left == 0) begin
          last_beat_cyc = cyc;
          if (burst_last) noise_cd = 10;
          else if (mean_en) mean_cd = 5;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic pulse_en();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic push_pixels(input int n, input bit stall);
    int sent = 0;
    int budget = 0;
    bit phase = 1'b0;
    while (sent < n && budget < 5000) begin
      @(negedge clk);
      budget++;
      if (stall && phase) begin
        pix_valid = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pix_data  = pix_val(pix_idx);
        if (pix_ready) begin
          exp_q.push_back(pix_data);
          pix_idx++;
          sent++;
        end
      end
      phase = ~phase;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    check("push_done", 32'(sent), 32'(n));
  endtask

  task automatic wait_nv(input int target, input int budget);
    int k = 0;
    while (n_nv < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("noise_valid_wait", 32'(n_nv), 32'(target));
  endtask

  initial begin
    // Reset and idle
    do_reset();
    check("rst_noise_out", 32'(noise_out), 0);
    check("rst_noise_valid", 32'(noise_valid), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_pix_ready", 32'(pix_ready), 1);
    check("rst_start_data", 32'(ne_start_data), 0);
    check("rst_sof", 32'(ne_start_of_frame), 0);
    check("rst_eof", 32'(ne_end_of_frame), 0);
    check("rst_ne_data", 32'(ne_data), 0);
    check("rst_bpf", ne_blocks_per_frame, 1);

    // Single frame of four blocks; blocks_per_frame changes mid-frame
    pix_idx = 0;
    noise_val = 16'h1234;
    blocks_per_frame = 4;
    pulse_en();
    blocks_per_frame = 7;
    push_pixels(64, 1'b0);
    wait_nv(1, 600);
    repeat (20) @(negedge clk);
    check("sf_starts", 32'(n_start), 4);
    check("sf_sof_first", 32'(sof_hist[0]), 1);
    check("sf_sof_count", 32'(n_sof), 1);
    check("sf_eof_fourth", 32'(eof_hist[3]), 1);
    check("sf_eof_count", 32'(n_eof), 1);
    check("sf_beat0", 32'(first_beats[0]), 184);
    check("sf_beat1", 32'(first_beats[1]), 76);
    check("sf_noise_out", 32'(noise_out), 32'h1234);
    check("sf_nv_pulses", 32'(n_nv), 1);
    check("sf_frame_count", 32'(frame_count), 1);
    check("sf_bpf_latched", ne_blocks_per_frame, 4);
    check("sf_busy", 32'(busy), 0);

    // Two frames back to back with en held high
    do_reset();
    noise_val = 16'hBEEF;
    blocks_per_frame = 4;
    @(negedge clk); en = 1'b1;
    push_pixels(128, 1'b0);
    wait_nv(2, 800);
    check("tf_starts", 32'(n_start), 8);
    check("tf_sof_count", 32'(n_sof), 2);
    check("tf_eof_count", 32'(n_eof), 2);
    check("tf_sof_fifth", 32'(sof_hist[4]), 1);
    check("tf_eof_eighth", 32'(eof_hist[7]), 1);
    check("tf_frame_count", 32'(frame_count), 2);
    check("tf_noise_out", 32'(noise_out), 32'hBEEF);
    en = 1'b0;

    // Fill to capacity with the controller idle, then drain two blocks
    do_reset();
    push_pixels(31, 1'b0);
    check("fill31_ready", 32'(pix_ready), 1);
    push_pixels(1, 1'b0);
    check("fill32_ready", 32'(pix_ready), 0);
    noise_val = 16'h0A5C;
    blocks_per_frame = 2;
    pulse_en();
    wait_nv(1, 400);
    check("fill_starts", 32'(n_start), 2);
    check("fill_noise_out", 32'(noise_out), 32'h0A5C);
    check("fill_ready_after", 32'(pix_ready), 1);

    // Upstream stalls every other cycle
    do_reset();
    noise_val = 16'h7E01;
    blocks_per_frame = 4;
    pulse_en();
    push_pixels(64, 1'b1);
    wait_nv(1, 1500);
    check("stall_starts", 32'(n_start), 4);
    check("stall_frame_count", 32'(frame_count), 1);
    check("stall_noise_out", 32'(noise_out), 32'h7E01);

    // blocks_per_frame = 0 behaves as a single block; no mean_ready given
    do_reset();
    mean_en = 1'b0;
    noise_val = 16'h00FF;
    blocks_per_frame = 0;
    pulse_en();
    check("bpf0_latched", ne_blocks_per_frame, 1);
    check("bpf0_busy", 32'(busy), 1);
    push_pixels(16, 1'b0);
    wait_nv(1, 300);
    check("bpf0_starts", 32'(n_start), 1);
    check("bpf0_sof", 32'(sof_hist[0]), 1);
    check("bpf0_eof", 32'(eof_hist[0]), 1);
    check("bpf0_err", 32'(err_timeout), 0);
    check("bpf0_frame_count", 32'(frame_count), 1);
    check("bpf0_noise_out", 32'(noise_out), 32'h00FF);

    // Watchdog: estimator never raises mean_ready
    do_reset();
    blocks_per_frame = 2;
    pulse_en();
    push_pixels(32, 1'b0);
    begin
      int k = 0;
      while (!err_timeout && k < 300) begin
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
    check("to_err", 32'(err_timeout), 1);
    check("to_latency", 32'(err_cyc - last_beat_cyc), 32'(TO + 1));
    check("to_busy", 32'(busy), 0);
    check("to_starts", 32'(n_start), 1);
    exp_q.delete();
    push_pixels(16, 1'b0);
    check("to_flushed_ready", 32'(pix_ready), 1);
    check("to_err_sticky", 32'(err_timeout), 1);
    do_reset();
    check("to_err_cleared", 32'(err_timeout), 0);
    mean_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
